muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (reset==0 resets).
REQ-003 SHALL have port op_valid, input, 1 bit: operation request.
REQ-004 SHALL have port op_ready, output, 1 bit: the block can accept an operation this cycle.
REQ-005 SHALL have port op_code, input, 2 bits: 00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO.
REQ-006 SHALL have port op_a, input, 32 bits: multiplicand, dividend or move source.
REQ-007 SHALL have port op_b, input, 32 bits: multiplier or divisor.
REQ-008 SHALL have port rd_sel, input, 1 bit: read select, 0 selects LO and 1 selects HI.
REQ-009 SHALL have port rd_data, output, 32 bits: contents of the selected HI/LO register (combinational).
REQ-010 SHALL have port busy, output, 1 bit: a multi-cycle operation is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when a MULTU or DIVU completes.
REQ-012 SHALL have port div_by_zero, output, 1 bit: the last DIVU had op_b==0.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 SHALL drive op_ready=1 only in IDLE; an operation is accepted on a rising edge where op_valid&&op_ready.
REQ-015 SHALL ignore op_valid, with no state change, in RUN and DONE.
REQ-016 SHALL complete MTHI/MTLO at the accept edge: HI or LO := op_a; FSM stays IDLE; no done pulse.
REQ-017 SHALL, on accepting MULTU, latch op_a, load product register {33'b0, op_b}, clear the 5-bit step counter and enter RUN.
REQ-018 SHALL perform one MULTU step per RUN cycle: if product[0], upper 33 bits += {1'b0, mcnd}; then shift the whole register right by 1.
REQ-019 SHALL, on accepting DIVU with op_b!=0, latch the divisor, set quotient := op_a and remainder := 0, and enter RUN.
REQ-020 SHALL perform one restoring-division step per RUN cycle: shift {rem, quo} left by 1; if rem >= divisor, subtract the divisor and set quo[0]=1.
REQ-021 SHALL leave RUN after exactly 32 steps (counter==31): write HI/LO at that edge (MULTU: HI=product[63:32], LO=product[31:0]; DIVU: HI=remainder, LO=quotient) and enter DONE.
REQ-022 SHALL assert done=1 for the single DONE cycle, then return to IDLE.
REQ-023 SHALL give MULTU/DIVU a latency of 33 edges from accept to DONE entry; op_ready SHALL return on the 34th edge.
REQ-024 SHALL, for DIVU with op_b==0, skip RUN and enter DONE on the next edge with HI=op_a, LO=32'hFFFFFFFF and div_by_zero=1.
REQ-025 SHALL hold div_by_zero until the next accepted MULTU/DIVU, which clears it.
REQ-026 SHALL assert busy in RUN and DONE.
REQ-027 SHALL keep the old HI/LO on rd_data while busy; the new values become visible from DONE onward.
REQ-028 SHALL keep all arithmetic unsigned modulo widths; the internal adder/subtractor SHALL be 33 bits so the carry/borrow is not lost.

Reset
REQ-029 SHALL, when reset is asserted (including mid-operation), asynchronously force: state=IDLE, HI=LO=0, counter=0, operand and working registers=0, busy=0, done=0, div_by_zero=0, op_ready=0 while reset is asserted.
REQ-030 SHALL drive op_ready=1 on the first clock after reset deasserts; an aborted operation SHALL leave no HI/LO update.

Structure
REQ-031 SHALL place the op_code encodings, the FSM state encoding and the step count (32) in the shared package muldiv_pkg.
REQ-032 SHALL place the per-step add/subtract-and-shift datapath in one sub-module, muldiv_step, which is combinational; muldiv_seq holds all registers.

Verification
REQ-033 SHALL test MULTU op_a=op_b=32'hFFFFFFFF -> done on the 33rd edge after accept; HI=32'hFFFFFFFE, LO=32'h00000001.
REQ-034 SHALL test DIVU op_a=100, op_b=7 -> LO=14, HI=2, div_by_zero=0.
REQ-035 SHALL test DIVU op_a=32'h12345678, op_b=0 -> done after 1 cycle; HI=32'h12345678, LO=32'hFFFFFFFF, div_by_zero=1; a following MULTU 3*5 clears the flag and gives LO=15, HI=0.
REQ-036 SHALL test MTHI 32'hDEADBEEF, then MULTU 2*3 with another op_valid held through RUN -> rd_sel=1 reads 32'hDEADBEEF while busy, then 0 after done; the extra request is not accepted until op_ready=1.
REQ-037 SHALL test reset asserted at step 10 of MULTU 7*9 -> HI=LO=0, no done pulse, op_ready=1 one clock after release.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the sequential MULTU/DIVU unit: op codes, FSM states
// and the iteration count of the bit-serial datapath.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_DIVU  = 2'b01,
    OP_MTHI  = 2'b10,
    OP_MTLO  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  localparam int unsigned STEPS = 32;
  localparam int unsigned CNT_W = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on the shared
// 65-bit working register; purely combinational.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic        is_div,
  input  logic [64:0] acc,
  input  logic [31:0] opnd,
  output logic [64:0] acc_nxt
);

  logic [32:0] sum;
  logic [64:0] sh;
  logic [32:0] rem_sh;
  logic [32:0] diff;

  always_comb begin
    sum    = acc[64:32] + {1'b0, opnd};
    sh     = {acc[63:0], 1'b0};
    rem_sh = sh[64:32];
    // rem_sh < 2*divisor, so the 33-bit difference never wraps and its
    // top bit is a valid borrow flag
    diff   = rem_sh - {1'b0, opnd};
    acc_nxt = '0;
    if (is_div) begin
      if (!diff[32]) acc_nxt = {1'b0, diff[31:0], sh[31:1], 1'b1};
      else           acc_nxt = {1'b0, rem_sh[31:0], sh[31:0]};
    end else if (acc[0]) begin
      acc_nxt = {1'b0, sum, acc[31:1]};
    end else begin
      acc_nxt = {1'b0, acc[64:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential 32-bit unsigned multiply/divide unit with HI/LO result registers.
//   state | meaning
//   IDLE  | ready for an op; MTHI/MTLO complete here
//   RUN   | 32 datapath iterations, one per cycle
//   DONE  | results written, done pulse, back to IDLE
module muldiv_seq
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [1:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        rd_sel,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero
);

  state_e             state, state_nxt;
  logic [31:0]        hi, lo;
  logic [31:0]        opnd;
  logic [64:0]        acc, acc_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               dbz;
  logic               accept;
  logic               step_last;
  op_e                opc;

  assign opc       = op_e'(op_code);
  assign op_ready  = (state == S_IDLE) && reset;
  assign accept    = op_valid && op_ready;
  assign step_last = (cnt == CNT_LAST);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign div_by_zero = dbz;
  assign rd_data   = rd_sel ? hi : lo;

  muldiv_step u_step (
    .is_div  (is_div),
    .acc     (acc),
    .opnd    (opnd),
    .acc_nxt (acc_nxt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (opc == OP_MULTU)     state_nxt = S_RUN;
          else if (opc == OP_DIVU) state_nxt = (op_b == 32'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN:   if (step_last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi     <= '0;
      lo     <= '0;
      opnd   <= '0;
      acc    <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      dbz    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (opc)
              OP_MULTU: begin
                opnd   <= op_a;
                acc    <= {33'd0, op_b};
                cnt    <= '0;
                is_div <= 1'b0;
                dbz    <= 1'b0;
              end
              OP_DIVU: begin
                is_div <= 1'b1;
                cnt    <= '0;
                if (op_b == 32'd0) begin
                  hi  <= op_a;
                  lo  <= 32'hFFFF_FFFF;
                  dbz <= 1'b1;
                end else begin
                  opnd <= op_b;
                  acc  <= {33'd0, op_a};
                  dbz  <= 1'b0;
                end
              end
              OP_MTHI: hi <= op_a;
              OP_MTLO: lo <= op_a;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          acc <= acc_nxt;
          cnt <= cnt + CNT_W'(1);
          // product and {remainder, quotient} share the same layout
          if (step_last) begin
            hi <= acc_nxt[63:32];
            lo <= acc_nxt[31:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq: multiply, divide, divide by
// zero, HI/LO moves, busy-time read-back and mid-operation reset.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [1:0]  op_code;
  logic [31:0] op_a, op_b;
  logic        rd_sel;
  logic [31:0] rd_data;
  logic        busy, done, div_by_zero;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk         (clk),
    .reset       (reset),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_code     (op_code),
    .op_a        (op_a),
    .op_b        (op_b),
    .rd_sel      (rd_sel),
    .rd_data     (rd_data),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  // drive one request in the low phase; returns #1 after the accept edge
  task automatic issue(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op_valid = 1'b1; op_code = c; op_a = a; op_b = b;
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  // edges after the accept edge until done is seen (bounded)
  task automatic wait_done(output int edges);
    edges = 0;
    while (!done && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic rd(input logic s, output logic [31:0] v);
    rd_sel = s; #1; v = rd_data;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    total++; if (op_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got %b want 0", op_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got %b want 0", done); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL rst_dbz got %b want 0", div_by_zero); end
    rd(1'b0, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL rst_lo got %h want 0", v); end
    rd(1'b1, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL rst_hi got %h want 0", v); end
    @(negedge clk); reset = 1'b1; #1;
    total++; if (op_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got %b want 1", op_ready); end
  endtask

  // accept edge counts as edge 1, so done appears 32 edges after it (edge 33)
  task automatic test_multu_max;
    int e; logic [31:0] v;
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mul_busy got %b want 1", busy); end
    wait_done(e);
    total++; if (e !== 32) begin bad++; $display("FAIL mul_latency got %0d want 32", e); end
    rd(1'b1, v);
    total++; if (v !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mul_hi got %h want fffffffe", v); end
    rd(1'b0, v);
    total++; if (v !== 32'h0000_0001) begin bad++; $display("FAIL mul_lo got %h want 00000001", v); end
    @(posedge clk); #1;
    total++; if (op_ready !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL mul_ready34 got rdy=%b done=%b want 1 0", op_ready, done); end
  endtask

  task automatic test_divu;
    logic [31:0] ta [4] = '{32'd100, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF};
    logic [31:0] tb [4] = '{32'd7,   32'd1,         32'd9, 32'hFFFF_FFFF};
    logic [31:0] tq [4] = '{32'd14,  32'hFFFF_FFFF, 32'd0, 32'd1};
    logic [31:0] tr [4] = '{32'd2,   32'd0,         32'd5, 32'd0};
    int e; logic [31:0] v;
    for (int i = 0; i < 4; i++) begin
      issue(2'b01, ta[i], tb[i]);
      wait_done(e);
      total++; if (e !== 32) begin bad++; $display("FAIL div%0d_latency got %0d want 32", i, e); end
      rd(1'b0, v);
      total++; if (v !== tq[i]) begin bad++; $display("FAIL div%0d_lo got %h want %h", i, v, tq[i]); end
      rd(1'b1, v);
      total++; if (v !== tr[i]) begin bad++; $display("FAIL div%0d_hi got %h want %h", i, v, tr[i]); end
      total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL div%0d_dbz got %b want 0", i, div_by_zero); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div_zero;
    int e; logic [31:0] v;
    issue(2'b01, 32'h1234_5678, 32'd0);
    wait_done(e);
    total++; if (e !== 0) begin bad++; $display("FAIL dz_latency got %0d want 0", e); end
    rd(1'b1, v);
    total++; if (v !== 32'h1234_5678) begin bad++; $display("FAIL dz_hi got %h want 12345678", v); end
    rd(1'b0, v);
    total++; if (v !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dz_lo got %h want ffffffff", v); end
    total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dz_flag got %b want 1", div_by_zero); end
    @(posedge clk); #1;
    total++; if (op_ready !== 1'b1 || div_by_zero !== 1'b1) begin bad++; $display("FAIL dz_hold got rdy=%b dbz=%b want 1 1", op_ready, div_by_zero); end
    issue(2'b00, 32'd3, 32'd5);
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL dz_clear got %b want 0", div_by_zero); end
    wait_done(e);
    rd(1'b0, v);
    total++; if (v !== 32'd15) begin bad++; $display("FAIL dz_mul_lo got %h want 0000000f", v); end
    rd(1'b1, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL dz_mul_hi got %h want 0", v); end
    @(posedge clk); #1;
  endtask

  // MTHI, then MULTU with a second request (MTLO) held through RUN/DONE
  task automatic test_back_to_back;
    int e; int rd_bad; int rdy_bad; logic [31:0] v;
    issue(2'b10, 32'hDEAD_BEEF, 32'd0);
    rd(1'b1, v);
    total++; if (v !== 32'hDEAD_BEEF || busy !== 1'b0) begin bad++; $display("FAIL mthi got %h busy=%b want deadbeef 0", v, busy); end
    issue(2'b00, 32'd2, 32'd3);
    op_valid = 1'b1; op_code = 2'b11; op_a = 32'h0000_0055; op_b = 32'd0;
    rd_bad = 0; rdy_bad = 0; e = 0;
    while (!done && e < 100) begin
      rd(1'b1, v);
      if (v !== 32'hDEAD_BEEF) rd_bad++;
      rd(1'b0, v);
      if (v !== 32'd15) rd_bad++;
      if (op_ready !== 1'b0 || busy !== 1'b1) rdy_bad++;
      @(posedge clk); #1;
      e++;
    end
    total++; if (rd_bad !== 0) begin bad++; $display("FAIL busy_read got %0d wrong reads want 0", rd_bad); end
    total++; if (rdy_bad !== 0) begin bad++; $display("FAIL busy_ready got %0d wrong cycles want 0", rdy_bad); end
    total++; if (e !== 32) begin bad++; $display("FAIL b2b_latency got %0d want 32", e); end
    rd(1'b1, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL b2b_hi got %h want 0", v); end
    rd(1'b0, v);
    total++; if (v !== 32'd6) begin bad++; $display("FAIL b2b_lo got %h want 6", v); end
    @(posedge clk); #1;
    rd(1'b0, v);
    total++; if (v !== 32'd6 || op_ready !== 1'b1) begin bad++; $display("FAIL b2b_pending got lo=%h rdy=%b want 6 1", v, op_ready); end
    @(posedge clk); #1;
    op_valid = 1'b0;
    rd(1'b0, v);
    total++; if (v !== 32'h55) begin bad++; $display("FAIL b2b_mtlo got %h want 55", v); end
  endtask

  task automatic test_reset_mid;
    int seen; logic [31:0] v;
    issue(2'b00, 32'd7, 32'd9);
    repeat (10) @(posedge clk);
    #2; reset = 1'b0; #1;
    total++; if (busy !== 1'b0 || done !== 1'b0 || op_ready !== 1'b0) begin bad++; $display("FAIL mid_rst got busy=%b done=%b rdy=%b want 0 0 0", busy, done, op_ready); end
    rd(1'b1, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL mid_hi got %h want 0", v); end
    rd(1'b0, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL mid_lo got %h want 0", v); end
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if (op_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL mid_release got rdy=%b busy=%b want 1 0", op_ready, busy); end
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    rd(1'b0, v);
    total++; if (seen !== 0 || v !== 32'd0) begin bad++; $display("FAIL mid_nodone got done=%0d lo=%h want 0 0", seen, v); end
  endtask

  initial begin
    reset = 1'b0; op_valid = 1'b0; op_code = 2'b00;
    op_a = '0; op_b = '0; rd_sel = 1'b0;
    #12;
    test_reset;
    test_multu_max;
    test_divu;
    test_div_zero;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
